// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial_link transmitter/receiver pair.
// Both state machines and the frame-length arithmetic live here.
package serial_link_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // Bits on the line per frame: start + data + optional parity + stop.
   function automatic int frame_len(input int width, input int parity_en);
      return width + 2 + parity_en;
   endfunction

   // Bit counter width; it counts 0..width-1.
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_link_parity_gen.sv
// Parity of a data word. An even-parity bit is the XOR of all data bits.
// ODD_PARITY inverts that bit.
module parity_gen #(
   parameter int WIDTH      = 8,
   parameter int ODD_PARITY = 0
) (
   input  logic [WIDTH-1:0] data,
   output logic             parity
);

   assign parity = (^data) ^ (ODD_PARITY != 0);

endmodule

// File: rtl/serial_link.sv
// Bit-per-clock serial transmitter and receiver.
// Frame format: start 0, data MSB-first, optional parity, stop 1.
module serial_link
   import serial_link_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int ODD_PARITY = 0
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] TxData,
   input  logic             TxValid,
   output logic             TxReady,
   output logic             SerialDout,
   input  logic             SerialDin,
   output logic [WIDTH-1:0] RxData,
   output logic             RxValid,
   output logic             ParityErr,
   output logic             FrameErr
);

   localparam int            CW         = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
   localparam bit            HAS_PARITY = (PARITY_EN != 0);

   // ---------------- transmitter ----------------
   tx_state_t        tx_state_reg, tx_state_next;
   logic [WIDTH-1:0] tx_shift_reg, tx_shift_next;
   logic [CW-1:0]    tx_cnt_reg, tx_cnt_next;
   logic             tx_parity_reg, tx_parity_next;
   logic             tx_parity_calc;
   logic             dout_reg, dout_next;
   logic             tx_fire;

   assign TxReady    = (tx_state_reg == TX_IDLE) && !Rst;
   assign tx_fire    = TxValid && TxReady;
   assign SerialDout = dout_reg;

   parity_gen #(.WIDTH(WIDTH), .ODD_PARITY(ODD_PARITY)) u_tx_parity (
      .data   (TxData),
      .parity (tx_parity_calc)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         tx_state_reg  <= TX_IDLE;
         tx_shift_reg  <= '0;
         tx_cnt_reg    <= '0;
         tx_parity_reg <= 1'b0;
         dout_reg      <= 1'b1;
      end else begin
         tx_state_reg  <= tx_state_next;
         tx_shift_reg  <= tx_shift_next;
         tx_cnt_reg    <= tx_cnt_next;
         tx_parity_reg <= tx_parity_next;
         dout_reg      <= dout_next;
      end
   end

   // The state names the bit on the line in the same cycle. So dout_next
   // is the bit that belongs to the state being entered.
   always_comb begin
      tx_state_next  = tx_state_reg;
      tx_shift_next  = tx_shift_reg;
      tx_cnt_next    = tx_cnt_reg;
      tx_parity_next = tx_parity_reg;
      dout_next      = 1'b1;
      case (tx_state_reg)
         TX_IDLE: begin
            if (tx_fire) begin
               tx_state_next  = TX_START;
               tx_shift_next  = TxData;
               tx_parity_next = tx_parity_calc;
               dout_next      = 1'b0;
            end
         end
         TX_START: begin
            tx_state_next = TX_DATA;
            tx_cnt_next   = '0;
            dout_next     = tx_shift_reg[WIDTH-1];
            tx_shift_next = {tx_shift_reg[WIDTH-2:0], 1'b0};
         end
         TX_DATA: begin
            if (tx_cnt_reg == LAST_BIT) begin
               if (HAS_PARITY) begin
                  tx_state_next = TX_PARITY;
                  dout_next     = tx_parity_reg;
               end else begin
                  tx_state_next = TX_STOP;
               end
            end else begin
               tx_cnt_next   = tx_cnt_reg + CW'(1);
               dout_next     = tx_shift_reg[WIDTH-1];
               tx_shift_next = {tx_shift_reg[WIDTH-2:0], 1'b0};
            end
         end
         TX_PARITY: tx_state_next = TX_STOP;
         TX_STOP:   tx_state_next = TX_IDLE;
         default:   tx_state_next = TX_IDLE;
      endcase
   end

   // ---------------- receiver ----------------
   rx_state_t        rx_state_reg, rx_state_next;
   logic [WIDTH-1:0] rx_shift_reg, rx_shift_next;
   logic [CW-1:0]    rx_cnt_reg, rx_cnt_next;
   logic             rx_parity_bit_reg, rx_parity_bit_next;
   logic             rx_parity_calc;
   logic [WIDTH-1:0] rx_data_reg, rx_data_next;
   logic             rx_valid_reg, rx_valid_next;
   logic             parity_err_reg, parity_err_next;
   logic             frame_err_reg, frame_err_next;

   assign RxData    = rx_data_reg;
   assign RxValid   = rx_valid_reg;
   assign ParityErr = parity_err_reg;
   assign FrameErr  = frame_err_reg;

   parity_gen #(.WIDTH(WIDTH), .ODD_PARITY(ODD_PARITY)) u_rx_parity (
      .data   (rx_shift_reg),
      .parity (rx_parity_calc)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rx_state_reg      <= RX_IDLE;
         rx_shift_reg      <= '0;
         rx_cnt_reg        <= '0;
         rx_parity_bit_reg <= 1'b0;
         rx_data_reg       <= '0;
         rx_valid_reg      <= 1'b0;
         parity_err_reg    <= 1'b0;
         frame_err_reg     <= 1'b0;
      end else begin
         rx_state_reg      <= rx_state_next;
         rx_shift_reg      <= rx_shift_next;
         rx_cnt_reg        <= rx_cnt_next;
         rx_parity_bit_reg <= rx_parity_bit_next;
         rx_data_reg       <= rx_data_next;
         rx_valid_reg      <= rx_valid_next;
         parity_err_reg    <= parity_err_next;
         frame_err_reg     <= frame_err_next;
      end
   end

   always_comb begin
      rx_state_next      = rx_state_reg;
      rx_shift_next      = rx_shift_reg;
      rx_cnt_next        = rx_cnt_reg;
      rx_parity_bit_next = rx_parity_bit_reg;
      rx_data_next       = rx_data_reg;
      rx_valid_next      = 1'b0;
      parity_err_next    = parity_err_reg;
      frame_err_next     = frame_err_reg;
      case (rx_state_reg)
         RX_IDLE: begin
            if (!SerialDin) begin
               rx_state_next = RX_DATA;
               rx_cnt_next   = '0;
            end
         end
         RX_DATA: begin
            rx_shift_next = {rx_shift_reg[WIDTH-2:0], SerialDin};
            if (rx_cnt_reg == LAST_BIT) begin
               rx_state_next = HAS_PARITY ? RX_PARITY : RX_STOP;
            end else begin
               rx_cnt_next = rx_cnt_reg + CW'(1);
            end
         end
         RX_PARITY: begin
            rx_parity_bit_next = SerialDin;
            rx_state_next      = RX_STOP;
         end
         RX_STOP: begin
            // Frames with errors still complete; the error flags qualify them.
            rx_state_next   = RX_IDLE;
            rx_valid_next   = 1'b1;
            rx_data_next    = rx_shift_reg;
            parity_err_next = HAS_PARITY && (rx_parity_calc != rx_parity_bit_reg);
            frame_err_next  = !SerialDin;
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

endmodule
